// File: rtl/tron_pkg.sv
// Shared tron types: player direction encoding and its opposite, used by steering and movement.
package tron_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   localparam int unsigned DROP_W = 8;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         UP:      opposite = DOWN;
         DOWN:    opposite = UP;
         LEFT:    opposite = RIGHT;
         default: opposite = LEFT;
      endcase
   endfunction

endpackage

// File: rtl/tron_dir_fifo.sv
// Circular buffer of queued turns; DEPTH must be a power of two so pointers wrap naturally.
module tron_dir_fifo
   import tron_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_pix,
   input  logic                     rst_pix,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  dir_t                     wdata,
   output dir_t                     head,
   output dir_t                     tail,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   dir_t          mem_q [DEPTH];
   dir_t          mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count says they are valid.
   always_ff @(posedge clk_pix) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign tail  = mem_q[wr_ptr_q - PW'(1)];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/tron_dir_queue.sv
// Per-player steering front end: queues legal turn presses and applies one per game tick.
// Optional DIRQ_DROP_CNT_EN adds an 8-bit saturating count of rejected presses.
module tron_dir_queue
   import tron_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter dir_t        RST_DIR = RIGHT
) (
   input  logic                   clk_pix,
   input  logic                   rst_pix,
   input  logic                   load,
   input  logic [1:0]             init_dir,
   input  logic                   tick,
   input  logic                   btn_up,
   input  logic                   btn_down,
   input  logic                   btn_left,
   input  logic                   btn_right,
`ifdef DIRQ_DROP_CNT_EN
   output logic [DROP_W-1:0]      drop_cnt,
`endif
   output dir_t                   dir,
   output logic                   turned,
   output logic [$clog2(DEPTH):0] q_count
);

   dir_t       dir_q, dir_d;
   logic       turned_q, turned_d;
   logic [3:0] btn_prev_q, btn_prev_d;
   logic [3:0] btn_now, btn_edge;
   logic       cand_vld;
   dir_t       cand_dir;
   dir_t       ref_dir;
   logic       legal;
   logic       push, pop;
   dir_t       head, tail;
   logic       full, empty;

   // Bit order {up, down, left, right}.
   assign btn_now    = {btn_up, btn_down, btn_left, btn_right};
   assign btn_edge   = btn_now & ~btn_prev_q;
   assign btn_prev_d = btn_now;

   always_comb begin
      cand_vld = |btn_edge;
      if (btn_edge[0])      cand_dir = RIGHT;
      else if (btn_edge[1]) cand_dir = LEFT;
      else if (btn_edge[3]) cand_dir = UP;
      else                  cand_dir = DOWN;
   end

   // Legality is judged against where the snake will be heading once the queue drains.
   assign ref_dir = empty ? dir_q : tail;
   assign pop     = tick & ~empty & ~load;
   assign legal   = (cand_dir != ref_dir) && (cand_dir != opposite(ref_dir)) && !(full && !pop);
   assign push    = cand_vld & ~load & legal;

   always_comb begin
      dir_d = dir_q;
      if (load)     dir_d = dir_t'(init_dir);
      else if (pop) dir_d = head;
   end

   assign turned_d = pop;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         dir_q      <= RST_DIR;
         turned_q   <= 1'b0;
         btn_prev_q <= 4'hF;
      end else begin
         dir_q      <= dir_d;
         turned_q   <= turned_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   tron_dir_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .flush   (load),
      .push    (push),
      .pop     (pop),
      .wdata   (cand_dir),
      .head    (head),
      .tail    (tail),
      .count   (q_count),
      .full    (full),
      .empty   (empty)
   );

`ifdef DIRQ_DROP_CNT_EN
   logic [DROP_W-1:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (cand_vld && !load && !legal && (drop_q != {DROP_W{1'b1}})) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) drop_q <= '0;
      else         drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`endif

   assign dir    = dir_q;
   assign turned = turned_q;

endmodule

// File: tb/tb_tron_dir_queue.sv
// Self-checking bench for tron_dir_queue: directed table, hand sequences and a random run
// checked against a queue-based behavioural model.
module tb_tron_dir_queue;

   localparam int DEPTH = 4;
   localparam int DU = 0, DD = 1, DL = 2, DR = 3;
   localparam logic [3:0] BU = 4'b1000, BD = 4'b0100, BL = 4'b0010, BR = 4'b0001;

   logic       clk = 1'b0;
   logic       rst, load, tick;
   logic [1:0] init_dir;
   logic [3:0] btn;  // {up, down, left, right}
   logic [1:0] dir;
   logic       turned;
   logic [2:0] q_count;
`ifdef DIRQ_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tron_dir_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk_pix   (clk),
      .rst_pix   (rst),
      .load      (load),
      .init_dir  (init_dir),
      .tick      (tick),
      .btn_up    (btn[3]),
      .btn_down  (btn[2]),
      .btn_left  (btn[1]),
      .btn_right (btn[0]),
`ifdef DIRQ_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .dir       (dir),
      .turned    (turned),
      .q_count   (q_count)
   );

   // Behavioural model
   int         m_q[$];
   int         m_dir, m_turned, m_drop;
   logic [3:0] m_prev;

   function automatic int opp(input int d);
      case (d)
         DU: return DD;
         DD: return DU;
         DL: return DR;
         default: return DL;
      endcase
   endfunction

   task automatic model_step();
      logic [3:0] e;
      int cand, rf, pops;
      bit ok;
      if (rst) begin
         m_q.delete(); m_dir = DR; m_turned = 0; m_drop = 0; m_prev = 4'hF;
         return;
      end
      e = btn & ~m_prev;
      m_prev = btn;
      if (load) begin
         m_q.delete(); m_dir = int'(init_dir); m_turned = 0;
         return;
      end
      cand = -1;
      if (e[0]) cand = DR;
      else if (e[1]) cand = DL;
      else if (e[3]) cand = DU;
      else if (e[2]) cand = DD;
      rf = (m_q.size() > 0) ? m_q[$] : m_dir;
      pops = (tick && m_q.size() > 0) ? 1 : 0;
      ok = 0;
      if (cand >= 0) begin
         ok = (cand != rf) && (cand != opp(rf)) && (m_q.size() - pops < DEPTH);
         if (!ok && m_drop < 255) m_drop++;
      end
      if (pops == 1) begin
         m_dir = m_q.pop_front();
         m_turned = 1;
      end else begin
         m_turned = 0;
      end
      if (ok) m_q.push_back(cand);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_dir"}, int'(dir), m_dir);
      chk({tag, "_turned"}, int'(turned), m_turned);
      chk({tag, "_count"}, int'(q_count), m_q.size());
`ifdef DIRQ_DROP_CNT_EN
      chk({tag, "_drop"}, int'(drop_cnt), m_drop);
`endif
   endtask

   // Drive inputs, clock once, advance the model, sample 1 ns after the edge.
   task automatic step(input bit r, input bit l, input logic [1:0] i, input bit t,
                       input logic [3:0] b, input bit use_model, input string tag);
      rst = r; load = l; init_dir = i; tick = t; btn = b;
      @(posedge clk);
      model_step();
      #1;
      if (use_model) check_model(tag);
   endtask

   typedef struct {
      bit         rst;
      bit         load;
      logic [1:0] init;
      bit         tick;
      logic [3:0] btn;
      int         e_dir;
      int         e_turn;
      int         e_cnt;
      int         e_drop;
   } vec_t;

   vec_t tab[$];

   task automatic add(input bit r, input bit l, input logic [1:0] i, input bit t,
                      input logic [3:0] b, input int ed, input int et, input int ec,
                      input int edr);
      vec_t v;
      v.rst = r; v.load = l; v.init = i; v.tick = t; v.btn = b;
      v.e_dir = ed; v.e_turn = et; v.e_cnt = ec; v.e_drop = edr;
      tab.push_back(v);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; init_dir = 2'd0; tick = 1'b0; btn = 4'b0;
      m_prev = 4'hF; m_dir = DR; m_turned = 0; m_drop = 0;

      // Reset with RIGHT held, then UP press and a tick
      add(1, 0, 0, 0, BR, DR, 0, 0, 0);
      add(1, 0, 0, 0, BR, DR, 0, 0, 0);
      add(0, 0, 0, 0, BR, DR, 0, 0, 0);
      add(0, 0, 0, 0, 0,  DR, 0, 0, 0);
      add(0, 0, 0, 0, BU, DR, 0, 1, 0);
      add(0, 0, 0, 0, 0,  DR, 0, 1, 0);
      add(0, 0, 0, 1, 0,  DU, 1, 0, 0);
      add(0, 0, 0, 0, 0,  DU, 0, 0, 0);
      // Back to RIGHT; opposite and same presses are rejected
      add(0, 1, DR, 0, 0, DR, 0, 0, 0);
      add(0, 0, 0, 0, BL, DR, 0, 0, 1);
      add(0, 0, 0, 0, 0,  DR, 0, 0, 1);
      add(0, 0, 0, 0, BR, DR, 0, 0, 2);
      add(0, 0, 0, 0, 0,  DR, 0, 0, 2);
      // Fill the queue, overflow one press, then drain
      add(0, 0, 0, 0, BU, DR, 0, 1, 2);
      add(0, 0, 0, 0, 0,  DR, 0, 1, 2);
      add(0, 0, 0, 0, BL, DR, 0, 2, 2);
      add(0, 0, 0, 0, 0,  DR, 0, 2, 2);
      add(0, 0, 0, 0, BD, DR, 0, 3, 2);
      add(0, 0, 0, 0, 0,  DR, 0, 3, 2);
      add(0, 0, 0, 0, BR, DR, 0, 4, 2);
      add(0, 0, 0, 0, 0,  DR, 0, 4, 2);
      add(0, 0, 0, 0, BU, DR, 0, 4, 3);
      add(0, 0, 0, 0, 0,  DR, 0, 4, 3);
      add(0, 0, 0, 1, 0,  DU, 1, 3, 3);
      add(0, 0, 0, 1, 0,  DL, 1, 2, 3);
      add(0, 0, 0, 1, 0,  DD, 1, 1, 3);
      add(0, 0, 0, 1, 0,  DR, 1, 0, 3);
      add(0, 0, 0, 1, 0,  DR, 0, 0, 3);

      foreach (tab[k]) begin
         step(tab[k].rst, tab[k].load, tab[k].init, tab[k].tick, tab[k].btn, 0, "tab");
         chk($sformatf("tab%0d_dir", k), int'(dir), tab[k].e_dir);
         chk($sformatf("tab%0d_turned", k), int'(turned), tab[k].e_turn);
         chk($sformatf("tab%0d_count", k), int'(q_count), tab[k].e_cnt);
`ifdef DIRQ_DROP_CNT_EN
         chk($sformatf("tab%0d_drop", k), int'(drop_cnt), tab[k].e_drop);
`endif
      end

      // Full queue: pop and push in the same cycle keeps count at DEPTH
      step(0, 0, 0, 0, BU, 1, "f_u");
      step(0, 0, 0, 0, 0,  1, "f_0");
      step(0, 0, 0, 0, BL, 1, "f_l");
      step(0, 0, 0, 0, 0,  1, "f_0");
      step(0, 0, 0, 0, BD, 1, "f_d");
      step(0, 0, 0, 0, 0,  1, "f_0");
      step(0, 0, 0, 0, BR, 1, "f_r");
      step(0, 0, 0, 0, 0,  1, "f_0");
      step(0, 0, 0, 1, BU, 1, "pp");
      chk("pp_count", int'(q_count), 4);
      step(0, 0, 0, 0, 0,  1, "pp_0");
      step(0, 0, 0, 1, 0,  1, "pp_t");
      chk("pp_dir_l", int'(dir), DL);
      // UP and LEFT together: only LEFT is considered, UP is not counted as a drop
      step(0, 0, 0, 0, BU | BL, 1, "prio");
      chk("prio_count", int'(q_count), 4);
`ifdef DIRQ_DROP_CNT_EN
      chk("prio_drop", int'(drop_cnt), 3);
`endif
      step(0, 0, 0, 1, 0, 1, "dr1");
      chk("dr1_dir", int'(dir), DD);
      step(0, 0, 0, 1, 0, 1, "dr2");
      chk("dr2_dir", int'(dir), DR);
      step(0, 0, 0, 1, 0, 1, "dr3");
      chk("dr3_dir", int'(dir), DU);
      step(0, 0, 0, 1, 0, 1, "dr4");
      chk("dr4_dir", int'(dir), DL);
      chk("dr4_turned", int'(turned), 1);

      // Load overrides tick and press with three entries queued
      step(0, 0, 0, 0, BU, 1, "l_u");
      step(0, 0, 0, 0, 0,  1, "l_0");
      step(0, 0, 0, 0, BR, 1, "l_r");
      step(0, 0, 0, 0, 0,  1, "l_0");
      step(0, 0, 0, 0, BD, 1, "l_d");
      step(0, 0, 0, 0, 0,  1, "l_0");
      chk("l_count3", int'(q_count), 3);
      step(0, 1, DL, 1, BL, 1, "ld");
      chk("ld_count", int'(q_count), 0);
      chk("ld_dir", int'(dir), DL);
      chk("ld_turned", int'(turned), 0);
`ifdef DIRQ_DROP_CNT_EN
      chk("ld_drop", int'(drop_cnt), 3);
`endif
      step(0, 0, 0, 0, BL, 1, "ld_hold");

      // Reset overrides load
      step(0, 0, 0, 0, 0,  1, "rl_0");
      step(0, 0, 0, 0, BU, 1, "rl_u");
      step(1, 1, DU, 1, 0, 1, "rl");
      chk("rl_dir", int'(dir), DR);
      chk("rl_count", int'(q_count), 0);

      // Random run against the model
      for (int n = 0; n < 800; n++) begin
         logic [3:0] b;
         int sel;
         sel = $urandom_range(0, 7);
         if (sel < 4)       b = 4'b0001 << sel;
         else if (sel == 4) b = 4'b0;
         else if (sel == 5) b = 4'($urandom_range(0, 15));
         else               b = btn;
         step($urandom_range(0, 150) == 0, $urandom_range(0, 40) == 0,
              2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, b, 1, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
